// File: rtl/ctrl_pipe_decoder_if.sv
// Fetch-to-decode bus for ctrl_pipe_decoder: instruction handshake in, registered control word out.
// Handshake: Instr is consumed on a rising edge when InstrValid && InstrReady && !Flush; InstrReady never depends on InstrValid.
interface ctrl_pipe_decoder_if #(
  parameter int MCODEBITS = 9,
  parameter int OPWIDTH   = 3
);
  logic [MCODEBITS-1:0] Instr;
  logic                 InstrValid;
  logic                 Stall;
  logic                 Flush;
  logic                 InstrReady;
  logic                 CtrlValid;
  logic                 Branch;
  logic                 MemtoReg;
  logic                 MemWrite;
  logic                 ALUSrc;
  logic                 RegWrite;
  logic [OPWIDTH:0]     ALUOp;
  logic [1:0]           RegDst;
  logic                 Halt;
  logic                 IllegalOp;

  modport master (
    output Instr, InstrValid, Stall, Flush,
    input  InstrReady, CtrlValid, Branch, MemtoReg, MemWrite, ALUSrc,
           RegWrite, ALUOp, RegDst, Halt, IllegalOp
  );

  modport slave (
    input  Instr, InstrValid, Stall, Flush,
    output InstrReady, CtrlValid, Branch, MemtoReg, MemWrite, ALUSrc,
           RegWrite, ALUOp, RegDst, Halt, IllegalOp
  );
endinterface

// File: rtl/ctrl_pipe_decoder.sv
// Registered control decoder with halt drain FSM (RUN -> DRAIN -> HALTED).
// Optional feature macro CTRL_ILLEGAL_TRAP_EN: illegal opcodes become a sticky trap that drains like halt.
module ctrl_pipe_decoder #(
  parameter int MCODEBITS    = 9,
  parameter int OPBITS       = 4,
  parameter int OPWIDTH      = 3,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  ctrl_pipe_decoder_if.slave bus,
  output logic [1:0]        dbg_state
);
  localparam int AW = OPWIDTH + 1;

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

  typedef struct packed {
    logic          ctrl_valid;
    logic          branch;
    logic          memtoreg;
    logic          memwrite;
    logic          alusrc;
    logic          regwrite;
    logic [AW-1:0] aluop;
    logic [1:0]    regdst;
  } ctrl_t;

  // 4-bit ALU codes are zero-extended or truncated to the configured width.
  function automatic logic [AW-1:0] fit_op(input logic [3:0] code);
    logic [AW+3:0] wide;
    wide = {{AW{1'b0}}, code};
    return wide[AW-1:0];
  endfunction

  state_t            state;
  logic [3:0]        cnt;
  ctrl_t             ctrl_q;
  ctrl_t             bubble;
  ctrl_t             dec;
  logic              dec_stop;
  logic              ready;
  logic              accept;
  logic [OPBITS-1:0] op;
  logic              unused_instr;

  assign op           = bus.Instr[MCODEBITS-1 -: OPBITS];
  assign unused_instr = ^bus.Instr;
  assign ready        = (state == RUN) && !bus.Stall;
  assign accept       = bus.InstrValid && ready && !bus.Flush;

  always_comb begin
    bubble       = '0;
    bubble.aluop = fit_op(4'b0111);
  end

  always_comb begin
    dec            = bubble;
    dec.ctrl_valid = 1'b1;
    dec.regwrite   = 1'b1;
    dec_stop       = 1'b0;
    case (op)
      OPBITS'(0):  begin dec.memtoreg = 1'b1; dec.regdst = 2'd1; end
      OPBITS'(1):  begin dec.regwrite = 1'b0; dec.memwrite = 1'b1; end
      OPBITS'(2):  dec.aluop = fit_op(4'b0001);
      OPBITS'(3):  begin dec.aluop = fit_op(4'b0010); dec.branch = 1'b1; dec.regwrite = 1'b0; end
      OPBITS'(4):  dec.aluop = fit_op(4'b0011);
      OPBITS'(5):  begin dec.aluop = fit_op(4'b0110); dec.regdst = 2'd2; end
      OPBITS'(6):  begin dec.aluop = fit_op(4'b0100); dec.alusrc = 1'b1; dec.regdst = 2'd1; end
      OPBITS'(7):  begin dec.aluop = fit_op(4'b0101); dec.alusrc = 1'b1; dec.regdst = 2'd1; end
      OPBITS'(8):  begin dec.aluop = fit_op(4'b0111); dec.alusrc = 1'b1; dec.regdst = 2'd1; end
      OPBITS'(9):  begin dec.aluop = fit_op(4'b1000); dec.regdst = 2'd2; end
      OPBITS'(10): begin dec.regwrite = 1'b0; dec_stop = 1'b1; end
      OPBITS'(11): dec.aluop = fit_op(4'b1010);
      OPBITS'(12): dec.aluop = fit_op(4'b1011);
      default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        dec      = bubble;
        dec_stop = 1'b1;
`endif
      end
    endcase
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  logic dec_illegal;
  assign dec_illegal   = (op > OPBITS'(12));
  assign bus.IllegalOp = illegal_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                      illegal_q <= 1'b0;
    else if (accept && dec_illegal) illegal_q <= 1'b1;
  end
`else
  assign bus.IllegalOp = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= RUN;
      cnt    <= '0;
      ctrl_q <= bubble;
    end else begin
      // Flush beats Stall; anything not accepted becomes a bubble.
      if (bus.Flush)       ctrl_q <= bubble;
      else if (bus.Stall)  ctrl_q <= ctrl_q;
      else if (accept)     ctrl_q <= dec;
      else                 ctrl_q <= bubble;

      case (state)
        RUN: begin
          if (accept && dec_stop) begin
            state <= DRAIN;
            cnt   <= 4'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          if (cnt == 4'd0)     state <= HALTED;
          else if (!bus.Stall) cnt   <= cnt - 4'd1;
        end
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

  assign bus.InstrReady = ready;
  assign bus.CtrlValid  = ctrl_q.ctrl_valid;
  assign bus.Branch     = ctrl_q.branch;
  assign bus.MemtoReg   = ctrl_q.memtoreg;
  assign bus.MemWrite   = ctrl_q.memwrite;
  assign bus.ALUSrc     = ctrl_q.alusrc;
  assign bus.RegWrite   = ctrl_q.regwrite;
  assign bus.ALUOp      = ctrl_q.aluop;
  assign bus.RegDst     = ctrl_q.regdst;
  assign bus.Halt       = (state == HALTED);
  assign dbg_state      = state;
endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// Directed bench for ctrl_pipe_decoder: opcode table, stall/flush priority, halt drain and reset recovery.
module tb_ctrl_pipe_decoder;
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_errors;
  logic [11:0] exp_q[$];
  logic [11:0] obs_word;

  localparam logic [11:0] BUBBLE_W = 12'b0_0_0_0_0_0_0111_00;
  localparam logic [11:0] HALT_W   = 12'b1_0_0_0_0_0_0111_00;
  localparam logic [11:0] NOP_W    = 12'b1_0_0_0_0_1_0111_00;

  ctrl_pipe_decoder_if #(.MCODEBITS(9), .OPWIDTH(3)) bus ();

  ctrl_pipe_decoder #(
    .MCODEBITS(9), .OPBITS(4), .OPWIDTH(3), .DRAIN_CYCLES(2)
  ) dut (
    .Clk       (clk),
    .Reset     (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  assign obs_word = {bus.CtrlValid, bus.Branch, bus.MemtoReg, bus.MemWrite,
                     bus.ALUSrc, bus.RegWrite, bus.ALUOp, bus.RegDst};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {CtrlValid,Branch,MemtoReg,MemWrite,ALUSrc,RegWrite,ALUOp[3:0],RegDst[1:0]}
  function automatic logic [11:0] exp_word(input logic [3:0] op);
    case (op)
      4'd0:    return 12'b1_0_1_0_0_1_0111_01;
      4'd1:    return 12'b1_0_0_1_0_0_0111_00;
      4'd2:    return 12'b1_0_0_0_0_1_0001_00;
      4'd3:    return 12'b1_1_0_0_0_0_0010_00;
      4'd4:    return 12'b1_0_0_0_0_1_0011_00;
      4'd5:    return 12'b1_0_0_0_0_1_0110_10;
      4'd6:    return 12'b1_0_0_0_1_1_0100_01;
      4'd7:    return 12'b1_0_0_0_1_1_0101_01;
      4'd8:    return 12'b1_0_0_0_1_1_0111_01;
      4'd9:    return 12'b1_0_0_0_0_1_1000_10;
      4'd10:   return HALT_W;
      4'd11:   return 12'b1_0_0_0_0_1_1010_00;
      4'd12:   return 12'b1_0_0_0_0_1_1011_00;
      default: return NOP_W;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [3:0] op, input logic v, input logic st, input logic fl);
    bus.Instr      = {op, 5'b10110};
    bus.InstrValid = v;
    bus.Stall      = st;
    bus.Flush      = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    automatic logic [3:0] sweep_ops [10] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11, 4'd12};
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    drive(4'd0, 1'b0, 1'b0, 1'b0);
    #12;
    check("reset_word", 32'(obs_word), 32'(BUBBLE_W));
    check("reset_halt", 32'(bus.Halt), 32'd0);
    check("reset_illegal", 32'(bus.IllegalOp), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    check("reset_ready", 32'(bus.InstrReady), 32'd1);
    step();
    rst = 1'b0;

    // load then store
    drive(4'd0, 1'b1, 1'b0, 1'b0);
    step();
    check("load_word", 32'(obs_word), 32'(exp_word(4'd0)));
    drive(4'd1, 1'b1, 1'b0, 1'b0);
    step();
    check("store_word", 32'(obs_word), 32'(exp_word(4'd1)));

    // back-to-back opcode sweep through the expected queue
    for (int i = 0; i < 10; i++) begin
      drive(sweep_ops[i], 1'b1, 1'b0, 1'b0);
      exp_q.push_back(exp_word(sweep_ops[i]));
      step();
      check("sweep_word", 32'(obs_word), 32'(exp_q.pop_front()));
    end
    drive(4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("idle_bubble", 32'(obs_word), 32'(BUBBLE_W));

    // add followed by two stalled cycles
    drive(4'd4, 1'b1, 1'b0, 1'b0);
    step();
    check("add_word", 32'(obs_word), 32'(exp_word(4'd4)));
    drive(4'd2, 1'b1, 1'b1, 1'b0);
    #1;
    check("stall_ready", 32'(bus.InstrReady), 32'd0);
    step();
    check("stall_hold1", 32'(obs_word), 32'(exp_word(4'd4)));
    step();
    check("stall_hold2", 32'(obs_word), 32'(exp_word(4'd4)));
    drive(4'd2, 1'b0, 1'b0, 1'b0);
    step();
    check("stall_release", 32'(obs_word), 32'(BUBBLE_W));

    // flush wins over stall
    drive(4'd4, 1'b1, 1'b0, 1'b0);
    step();
    drive(4'd3, 1'b1, 1'b1, 1'b1);
    step();
    check("flush_stall_word", 32'(obs_word), 32'(BUBBLE_W));
    check("flush_stall_branch", 32'(bus.Branch), 32'd0);

    // flushed halt is not accepted
    drive(4'd10, 1'b1, 1'b0, 1'b1);
    step();
    check("flush_halt_state", 32'(dbg_state), 32'd0);
    check("flush_halt_word", 32'(obs_word), 32'(BUBBLE_W));

    // halt with one stalled drain cycle: Halt rises 4 edges after acceptance
    drive(4'd10, 1'b1, 1'b0, 1'b0);
    step();
    check("halt_word", 32'(obs_word), 32'(HALT_W));
    check("halt_state_drain", 32'(dbg_state), 32'd1);
    check("drain_ready", 32'(bus.InstrReady), 32'd0);
    drive(4'd4, 1'b1, 1'b1, 1'b0);
    step();
    check("drain_e1_halt", 32'(bus.Halt), 32'd0);
    check("drain_e1_hold", 32'(obs_word), 32'(HALT_W));
    drive(4'd4, 1'b1, 1'b0, 1'b0);
    step();
    check("drain_e2_halt", 32'(bus.Halt), 32'd0);
    check("drain_e2_word", 32'(obs_word), 32'(BUBBLE_W));
    step();
    check("drain_e3_halt", 32'(bus.Halt), 32'd0);
    step();
    check("drain_e4_halt", 32'(bus.Halt), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(4'd0, 1'b1, 1'b0, 1'b0);
      step();
      check("halted_word", 32'(obs_word), 32'(BUBBLE_W));
      check("halted_halt", 32'(bus.Halt), 32'd1);
    end

    // asynchronous reset out of HALTED, first instruction taken next edge
    rst = 1'b1;
    #2;
    check("rst_halt_clear", 32'(bus.Halt), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_word", 32'(obs_word), 32'(BUBBLE_W));
    rst = 1'b0;
    drive(4'd0, 1'b1, 1'b0, 1'b0);
    step();
    check("post_rst_load", 32'(obs_word), 32'(exp_word(4'd0)));

    // illegal opcode 1110
    drive(4'd14, 1'b1, 1'b0, 1'b0);
    step();
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("illegal_word", 32'(obs_word), 32'(BUBBLE_W));
    check("illegal_flag", 32'(bus.IllegalOp), 32'd1);
    check("illegal_state", 32'(dbg_state), 32'd1);
    drive(4'd0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    step();
    check("illegal_halt", 32'(bus.Halt), 32'd1);
    check("illegal_sticky", 32'(bus.IllegalOp), 32'd1);
    rst = 1'b1;
    #2;
    check("illegal_rst", 32'(bus.IllegalOp), 32'd0);
    rst = 1'b0;
`else
    check("illegal_word", 32'(obs_word), 32'(NOP_W));
    check("illegal_flag", 32'(bus.IllegalOp), 32'd0);
    check("illegal_state", 32'(dbg_state), 32'd0);
`endif
    drive(4'd0, 1'b0, 1'b0, 1'b0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
